// File: rtl/xbar_varlat_ordered.sv
// Full NumIn x NumOut crossbar for variable-latency targets.
// Per-target route FIFOs plus a per-requestor count/lock keep responses in issue order.

module xbar_varlat_route_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Depth-1:0][Width-1:0] mem_q;
    logic [PtrW-1:0]             wr_q, rd_q;
    logic [CntW-1:0]             cnt_q;
    logic                        do_push, do_pop;

    function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            if (do_push && !do_pop) cnt_q <= cnt_q + CntW'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
        end
    end
endmodule

module xbar_varlat_ordered #(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned NumOut         = 4,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned RouteFifoDepth = 4,
    parameter logic        WriteRespEn    = 1'b1,
    localparam int unsigned AddrW = (NumOut > 1) ? $clog2(NumOut) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumIn-1:0]                        req_i,
    input  logic [NumIn-1:0][AddrW-1:0]             add_i,
    input  logic [NumIn-1:0]                        wen_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]      wdata_i,
    output logic [NumIn-1:0]                        gnt_o,
    output logic [NumIn-1:0]                        vld_o,
    output logic [NumIn-1:0][RespDataWidth-1:0]     rdata_o,
    output logic [NumOut-1:0]                       req_o,
    output logic [NumOut-1:0]                       wen_o,
    output logic [NumOut-1:0][ReqDataWidth-1:0]     wdata_o,
    input  logic [NumOut-1:0]                       gnt_i,
    input  logic [NumOut-1:0]                       vld_i,
    input  logic [NumOut-1:0][RespDataWidth-1:0]    rdata_i,
    output logic [NumOut-1:0]                       spurious_o
);
    localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [NumIn-1:0][CntW-1:0]   cnt_q, cnt_d;
    logic [NumIn-1:0][AddrW-1:0]  lock_q, lock_d;
    logic [NumOut-1:0][IdxW-1:0]  ptr_q, ptr_d;

    logic [NumOut-1:0]            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [NumOut-1:0][IdxW-1:0]  fifo_head;
    logic [NumOut-1:0][IdxW-1:0]  sel;
    logic [NumOut-1:0]            sel_vld;
    logic [NumOut-1:0][NumIn-1:0] elig;
    logic [NumIn-1:0]             tracked;

    for (genvar k = 0; k < NumOut; k++) begin : g_route
        xbar_varlat_route_fifo #(
            .Depth (RouteFifoDepth),
            .Width (IdxW)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (fifo_push[k]),
            .data_i  (sel[k]),
            .pop_i   (fifo_pop[k]),
            .head_o  (fifo_head[k]),
            .full_o  (fifo_full[k]),
            .empty_o (fifo_empty[k])
        );
    end

    // Full check uses registered occupancy only, so vld_i never reaches gnt_o.
    always_comb begin
        elig    = '0;
        tracked = '0;
        for (int j = 0; j < int'(NumIn); j++) begin
            tracked[j] = !wen_i[j] || WriteRespEn;
            for (int k = 0; k < int'(NumOut); k++) begin
                if (req_i[j] && (add_i[j] == AddrW'(k)) &&
                    ((cnt_q[j] == '0) || (lock_q[j] == AddrW'(k))) &&
                    (!tracked[j] || ((cnt_q[j] < CntW'(MaxOutstanding)) && !fifo_full[k])))
                    elig[k][j] = 1'b1;
            end
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        sel     = '0;
        sel_vld = '0;
        for (int k = 0; k < int'(NumOut); k++) begin
            for (int o = 0; o < int'(NumIn); o++) begin
                idx = int'(ptr_q[k]) + o;
                if (idx >= int'(NumIn)) idx = idx - int'(NumIn);
                if (!sel_vld[k] && elig[k][idx]) begin
                    sel_vld[k] = 1'b1;
                    sel[k]     = IdxW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_o      = '0;
        wen_o      = '0;
        wdata_o    = '0;
        gnt_o      = '0;
        vld_o      = '0;
        rdata_o    = '0;
        spurious_o = '0;
        fifo_push  = '0;
        fifo_pop   = '0;
        if (!rst_i) begin
            for (int k = 0; k < int'(NumOut); k++) begin
                req_o[k] = sel_vld[k];
                if (sel_vld[k]) begin
                    wen_o[k]   = wen_i[sel[k]];
                    wdata_o[k] = wdata_i[sel[k]];
                    if (gnt_i[k]) begin
                        gnt_o[sel[k]] = 1'b1;
                        fifo_push[k]  = tracked[sel[k]];
                    end
                end
                if (vld_i[k]) begin
                    if (fifo_empty[k]) begin
                        spurious_o[k] = 1'b1;
                    end else begin
                        fifo_pop[k]            = 1'b1;
                        vld_o[fifo_head[k]]    = 1'b1;
                        rdata_o[fifo_head[k]]  = rdata_o[fifo_head[k]] | rdata_i[k];
                    end
                end
            end
        end
    end

    // A requestor targets one slave at a time, so push and pop are each at most one per requestor.
    always_comb begin
        logic inc, dec;
        inc    = 1'b0;
        dec    = 1'b0;
        cnt_d  = cnt_q;
        lock_d = lock_q;
        ptr_d  = ptr_q;
        for (int j = 0; j < int'(NumIn); j++) begin
            inc = gnt_o[j] && tracked[j];
            dec = 1'b0;
            for (int k = 0; k < int'(NumOut); k++)
                if (fifo_pop[k] && (fifo_head[k] == IdxW'(j))) dec = 1'b1;
            if (inc && !dec) cnt_d[j] = cnt_q[j] + CntW'(1);
            else if (dec && !inc) cnt_d[j] = cnt_q[j] - CntW'(1);
            if (inc) lock_d[j] = add_i[j];
        end
        for (int k = 0; k < int'(NumOut); k++) begin
            if (req_o[k] && gnt_i[k])
                ptr_d[k] = (sel[k] == IdxW'(NumIn - 1)) ? '0 : sel[k] + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            lock_q <= '0;
            ptr_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            ptr_q  <= ptr_d;
        end
    end
endmodule

// File: tb/tb_xbar_varlat_ordered.sv
// Bench for xbar_varlat_ordered: default instance plus a write-untracked, depth-2 FIFO instance.
module tb_xbar_varlat_ordered;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int DW = 32;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0]          req, wen;
    logic [NI-1:0][AW-1:0]  add;
    logic [NI-1:0][DW-1:0]  wdata;
    logic [NO-1:0]          gnt_t, vld_t;
    logic [NO-1:0][DW-1:0]  rdata_t;

    logic [NI-1:0]          gnt_o, vld_o, gnt2_o, vld2_o;
    logic [NI-1:0][DW-1:0]  rdata_o, rdata2_o;
    logic [NO-1:0]          req_o, wen_o, spur_o, req2_o, wen2_o, spur2_o;
    logic [NO-1:0][DW-1:0]  wdata_o, wdata2_o;

    always #5 clk = ~clk;

    xbar_varlat_ordered dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o), .req_o(req_o), .wen_o(wen_o),
        .wdata_o(wdata_o), .gnt_i(gnt_t), .vld_i(vld_t), .rdata_i(rdata_t), .spurious_o(spur_o)
    );

    xbar_varlat_ordered #(.WriteRespEn(1'b0), .RouteFifoDepth(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .gnt_o(gnt2_o), .vld_o(vld2_o), .rdata_o(rdata2_o), .req_o(req2_o), .wen_o(wen2_o),
        .wdata_o(wdata2_o), .gnt_i(gnt_t), .vld_i(vld_t), .rdata_i(rdata_t), .spurious_o(spur2_o)
    );

    typedef struct { int m; logic [DW-1:0] d; } sb_t;
    sb_t sb_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; wen = '0; add = '0; wdata = '0;
        gnt_t = '0; vld_t = '0; rdata_t = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic sb_push(input int m, input logic [DW-1:0] d);
        sb_t e;
        e.m = m;
        e.d = d;
        sb_q.push_back(e);
    endtask

    task automatic drive_rsp(input int k);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
            return;
        end
        vld_t[k]   = 1'b1;
        rdata_t[k] = sb_q[0].d;
    endtask

    task automatic check_rsp();
        sb_t e;
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk("rsp_vld", vld_o, 64'(1) << e.m);
        chk("rsp_data", rdata_o[e.m], e.d);
        chk("rsp_idle_data", rdata_o[(e.m + 1) % NI], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // 1: four masters load from target 2, round-robin grants then in-order responses
        do_reset();
        req = 4'hF; add = {2'd2, 2'd2, 2'd2, 2'd2}; gnt_t = 4'hF;
        for (int n = 0; n < 4; n++) begin
            settle();
            chk("rr_gnt", gnt_o, 64'(1) << n);
            if (n == 0) chk("rr_req_o", req_o, 4'b0100);
            sb_push(n, 32'hA0 + 32'(n));
            tick();
            req[n] = 1'b0;
        end
        for (int n = 0; n < 4; n++) begin
            drive_rsp(2);
            settle();
            check_rsp();
            tick();
        end
        vld_t = '0;
        settle();
        chk("rr_quiet", vld_o, 0);

        // 2: master 1 fills target 0 then one response frees a slot
        do_reset();
        req = 4'b0010; add[1] = 2'd0; gnt_t = 4'hF;
        for (int n = 0; n < 4; n++) begin
            settle();
            chk("out_gnt", gnt_o, 4'b0010);
            sb_push(1, $urandom);
            tick();
        end
        settle();
        chk("out_block", gnt_o, 0);
        drive_rsp(0);
        settle();
        chk("out_no_comb", gnt_o, 0);
        check_rsp();
        tick();
        vld_t = '0;
        settle();
        chk("out_regrant", gnt_o, 4'b0010);
        sb_push(1, $urandom);
        tick();
        req = '0;
        for (int n = 0; n < 4; n++) begin
            drive_rsp(0);
            settle();
            check_rsp();
            tick();
        end
        vld_t = '0;

        // 3: lock keeps master 0 on target 1 until its response returns
        do_reset();
        req = 4'b0001; add[0] = 2'd1; gnt_t = 4'hF;
        settle();
        chk("lock_first", gnt_o, 4'b0001);
        sb_push(0, $urandom);
        tick();
        add[0] = 2'd3;
        settle();
        chk("lock_block", gnt_o, 0);
        chk("lock_req", req_o, 0);
        tick();
        drive_rsp(1);
        settle();
        chk("lock_same_cyc", gnt_o, 0);
        check_rsp();
        tick();
        vld_t = '0;
        settle();
        chk("lock_release", gnt_o, 4'b0001);
        chk("lock_req3", req_o, 4'b1000);
        tick();
        req = '0;

        // 4: untracked store on the WriteRespEn=0 instance
        do_reset();
        req = 4'b0100; add[2] = 2'd0; wen[2] = 1'b1; wdata[2] = 32'h55; gnt_t = 4'hF;
        settle();
        chk("wr_gnt", gnt2_o, 4'b0100);
        chk("wr_wdata", wdata2_o[0], 32'h55);
        chk("wr_wen", wen2_o[0], 1);
        tick();
        req = '0; wen = '0;
        vld_t[0] = 1'b1; rdata_t[0] = 32'h77;
        settle();
        chk("wr_spur", spur2_o, 4'b0001);
        chk("wr_no_vld", vld2_o, 0);
        tick();
        vld_t = '0;
        settle();
        chk("wr_spur_clr", spur2_o, 0);

        // 5: depth-2 route FIFO on target 3
        do_reset();
        req = 4'hF; add = {2'd3, 2'd3, 2'd3, 2'd3}; gnt_t = 4'hF;
        for (int n = 0; n < 2; n++) begin
            settle();
            chk("ff_gnt", gnt2_o, 64'(1) << n);
            tick();
            req[n] = 1'b0;
        end
        settle();
        chk("ff_full", gnt2_o, 0);
        chk("ff_req_o", req2_o, 0);
        tick();
        vld_t[3] = 1'b1; rdata_t[3] = 32'h1234;
        settle();
        chk("ff_pop_nogo", gnt2_o, 0);
        chk("ff_rsp_vld", vld2_o, 4'b0001);
        chk("ff_rsp_data", rdata2_o[0], 32'h1234);
        tick();
        vld_t = '0;
        settle();
        chk("ff_next_gnt", gnt2_o, 4'b0100);
        tick();
        req = '0;

        // 6: reset with loads in flight drops all tracking
        do_reset();
        req = 4'b0011; add[0] = 2'd1; add[1] = 2'd1; gnt_t = 4'hF;
        settle();
        chk("mr_gnt0", gnt_o, 4'b0001);
        tick();
        req = 4'b0010;
        settle();
        chk("mr_gnt1", gnt_o, 4'b0010);
        tick();
        rst = 1'b1;
        req = 4'hF; wen = 4'hF; wdata = {4{32'hCAFE}}; vld_t = 4'hF; rdata_t = {4{32'hDEAD}};
        settle();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_req", req_o, 0);
        chk("rst_vld", vld_o, 0);
        chk("rst_spur", spur_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_wen", wen_o, 0);
        tick();
        rst = 1'b0;
        req = '0; wen = '0; vld_t = 4'b0010;
        settle();
        chk("post_spur", spur_o, 4'b0010);
        chk("post_vld", vld_o, 0);
        tick();
        vld_t = '0;

        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xbar_varlat_ordered.md
Name: xbar_varlat_ordered

Overview:
- Parametrised full crossbar, NumIn requestors to NumOut variable-latency targets, for the TCDM variable-latency interconnect.
- Each target keeps a route FIFO of granted requestor indices, so several requests can be in flight per target.
- A per-requestor outstanding counter and target lock make responses return to each requestor in issue order.
- Optional write responses and a spurious-response flag, neither present in the previous crossbar generation.

Parameters:
- NumIn, 4: number of requestors (>=1).
- NumOut, 4: number of targets (>=1).
- ReqDataWidth, 32: write data width.
- RespDataWidth, 32: read data width.
- MaxOutstanding, 4: max in-flight tracked requests per requestor (>=1).
- RouteFifoDepth, 4: per-target route FIFO entries, power of two, >=1.
- WriteRespEn, 1'b1: 1 = writes are tracked and answered with a response; 0 = writes are untracked and produce no vld.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NumIn  request.
- add_i  in  NumIn x max(1,$clog2(NumOut))  target index.
- wen_i  in  NumIn  1 = store, 0 = load.
- wdata_i  in  NumIn x ReqDataWidth  write data.
- gnt_o  out  NumIn  grant, combinational.
- vld_o  out  NumIn  response valid.
- rdata_o  out  NumIn x RespDataWidth  response data.
- req_o  out  NumOut  request to target.
- wen_o  out  NumOut  forwarded wen.
- wdata_o  out  NumOut x ReqDataWidth  forwarded write data.
- gnt_i  in  NumOut  target grant.
- vld_i  in  NumOut  target response valid.
- rdata_i  in  NumOut x RespDataWidth  target response data.
- spurious_o  out  NumOut  one-cycle pulse: vld_i arrived while the route FIFO was empty.

Behaviour:
- Reset (rst_i=1, sampled at clk_i edge):
  - Registered state cleared: all counters 0, all route FIFOs empty, all RR pointers 0, all lock registers 0.
  - While rst_i=1: req_o, gnt_o, vld_o and spurious_o are forced 0; rdata_o, wdata_o and wen_o are 0.
- Tracked request: any load; a store only when WriteRespEn=1.
- Eligibility of requestor j for target k=add_i[j]. All of the following must hold:
  - req_i[j]=1;
  - add_i[j] < NumOut;
  - cnt[j]==0, or lock[j]==k;
  - for a tracked request, cnt[j] < MaxOutstanding and route FIFO k is not full.
- Full FIFO blocks grants even if a pop happens in the same cycle; there is no combinational path from vld_i to gnt_o.
- Arbitration, per target:
  - Round-robin over the eligible requestors, starting at ptr[k].
  - req_o[k] = any requestor eligible; wdata_o[k] and wen_o[k] come from the selected requestor, and are 0 when none is selected.
  - gnt_o[j] = gnt_i[k] & (j selected by k).
  - On handshake (req_o[k] & gnt_i[k]): ptr[k] <= (winner+1) mod NumIn. Without a handshake ptr holds, so req/data stay stable while a target withholds its grant.
- Handshake with a tracked request:
  - push j into route FIFO k;
  - cnt[j]++;
  - lock[j] <= k.
- An untracked write handshake changes no counter and no FIFO.
- Response, zero latency, combinational:
  - vld_i[k] with FIFO k non-empty: h = head; vld_o[h]=1, rdata_o[h]=rdata_i[k]; pop; cnt[h]-- at the clock edge.
  - The lock guarantees at most one target can answer a given requestor per cycle.
  - rdata_o[j]=0 whenever vld_o[j]=0.
- Response on empty FIFO: vld_i[k] ignored; spurious_o[k]=1 for that cycle; no state change.
- Counter arithmetic:
  - Push and pop for the same requestor in the same cycle: cnt is unchanged.
  - cnt width is $clog2(MaxOutstanding+1); cnt never overflows or underflows.
- FIFO pointers wrap modulo RouteFifoDepth, with a separate full/empty indication. Push and pop in the same cycle on a non-empty FIFO keeps the occupancy.
- Reset mid-operation: all tracking is lost. Responses arriving from targets after reset raise spurious_o and are dropped.
- NumIn==1: arbitration degenerates to a pass-through; tracking is unchanged.

Test Plan:
- NumIn=NumOut=4, default parameters: masters 0..3 load from target 2 in the same cycle, gnt_i=1 every cycle -> grants go to 0, 1, 2, 3 in successive cycles. vld_i[2] pulses carrying rdata 0xA0..0xA3 return 0xA0..0xA3 to masters 0..3 in that order.
- Master 1 issues 4 loads to target 0 while vld_i is held low -> gnt_o[1]=0 on the 5th request. One vld_i[0] pulse -> the 5th request is granted the next cycle.
- Master 0 has 1 load outstanding on target 1 and requests target 3 -> no grant to master 0 until vld_i[1] returns. Master 0 is then granted on target 3 in the following cycle.
- WriteRespEn=0: master 2 stores 0x55 to target 0 -> wdata_o[0]=0x55, wen_o[0]=1, no FIFO push. A later vld_i[0] pulse -> spurious_o[0]=1 and vld_o stays 0.
- RouteFifoDepth=2, four masters load from target 3 with no responses -> only 2 grants. A simultaneous vld_i[3] plus a pending request in the same cycle -> no grant that cycle; the grant comes in the next cycle.
- 2 loads in flight, then rst_i=1 for 1 cycle -> all outputs 0 during reset. Subsequent vld_i pulses -> spurious_o asserted, vld_o=0.
